nv_minmax_scatter: RTL and testbench
====================================

NV_MINMAX_SCATTER -- requirements
Module: nv_minmax_scatter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: element bit width.
REQ-002 SHALL have parameter NUM_INPUTS, default 2, legal 2..64: number of lanes per expanded window.
REQ-003 SHALL have localparam INDEX_WIDTH = 1/2/3/4/5/6 for NUM_INPUTS <=2/<=4/<=8/<=16/<=32/<=64.
REQ-004 SHALL have port nvdla_core_clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port nvdla_core_rstn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_pvld, input, 1: a (value, index) pair is offered.
REQ-007 SHALL have port in_prdy, output, 1: the pair is accepted when in_pvld & in_prdy.
REQ-008 SHALL have port in_value, input, WIDTH: selected min/max value.
REQ-009 SHALL have port in_index, input, INDEX_WIDTH: lane that holds the selected value.
REQ-010 SHALL have port in_fill, input, WIDTH: value for all non-selected lanes, sampled on acceptance.
REQ-011 SHALL have port out_pvld, output, 1: output beat valid.
REQ-012 SHALL have port out_prdy, input, 1: downstream accepts the beat.
REQ-013 SHALL have port out_data, output, WIDTH: lane data.
REQ-014 SHALL have port out_pos, output, INDEX_WIDTH: lane number of the current beat.
REQ-015 SHALL have port out_last, output, 1: beat is lane NUM_INPUTS-1.

Function
REQ-016 SHALL implement two states: IDLE (no pair held) and EMIT (pair held, beats pending).
REQ-017 SHALL assert in_prdy in IDLE, and in EMIT only on the cycle a last beat handshakes (out_pvld & out_prdy & out_last).
REQ-018 SHALL, on acceptance, latch value, index and fill, set pos=0, enter EMIT; first beat valid next cycle (1-cycle latency).
REQ-019 SHALL in EMIT drive out_pvld=1, out_pos=pos, out_data=(pos==index)?value:fill, out_last=(pos==NUM_INPUTS-1).
REQ-020 SHALL hold all out_* stable while out_pvld & !out_prdy.
REQ-021 SHALL increment pos by 1 per output handshake and never exceed NUM_INPUTS-1.
REQ-022 SHALL, on last-beat handshake, go to IDLE if no new pair is accepted, or stay in EMIT with pos=0 and the new pair if one is accepted the same cycle (zero-bubble, NUM_INPUTS beats per NUM_INPUTS cycles).
REQ-023 SHALL treat in_index >= NUM_INPUTS as out-of-range: every lane emits fill.
REQ-024 SHALL not combinationally connect out_prdy to out_pvld; in_prdy may depend combinationally on out_prdy.

Reset
REQ-025 SHALL on nvdla_core_rstn low asynchronously enter IDLE, pos=0, out_pvld=0, out_data=0, out_pos=0, out_last=0, in_prdy=1 (after reset release), discarding any held pair mid-window.

Configuration
REQ-026 SHALL, with NV_MINMAX_SCATTER_ERR_EN defined, add output err_oob (1 bit, reset 0), set sticky on acceptance of an out-of-range in_index, and add input err_clr (1 bit) that clears it next cycle; a simultaneous set takes priority over clear.
REQ-027 SHALL, without NV_MINMAX_SCATTER_ERR_EN, omit err_oob and err_clr; out-of-range behaviour per REQ-023 is unchanged.

Structure
REQ-028 SHALL place the INDEX_WIDTH derivation function and the IDLE/EMIT state encoding in shared package nv_minmax_pkg for reuse by the min/max selector.
REQ-029 SHALL be a single module with no sub-module; the lane counter is inline.

Verification
REQ-030 SHALL cover: NUM_INPUTS=4, pair (value=0x5A, index=2, fill=0x00), out_prdy=1 -> beats 00,00,5A,00 on 4 consecutive cycles, out_last on pos 3.
REQ-031 SHALL cover: two pairs back-to-back, (0x11,0) then (0x22,3), out_prdy=1 -> 8 beats with no bubble, in_prdy high on cycle of first last beat.
REQ-032 SHALL cover: out_prdy low for 3 cycles at pos 1 -> out_data/out_pos/out_last held constant; in_prdy low throughout.
REQ-033 SHALL cover: NUM_INPUTS=3, index=3, fill=0xFF -> beats FF,FF,FF; with ERR_EN err_oob=1 until err_clr pulse.
REQ-034 SHALL cover: reset asserted at pos 2 of a 4-lane window -> out_pvld=0 immediately, after release in_prdy=1 and next pair starts at pos 0.

Source files
------------

// File: rtl/nv_minmax_pkg.sv
// nv_minmax_pkg: shared index-width derivation and IDLE/EMIT encoding for the min/max family.
package nv_minmax_pkg;

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic int idx_width(input int n);
        return n <= 2 ? 1 : n <= 4 ? 2 : n <= 8 ? 3 : n <= 16 ? 4 : n <= 32 ? 5 : 6;
    endfunction

endpackage

// File: rtl/nv_minmax_scatter.sv
// nv_minmax_scatter: expands a (value, index, fill) pair into NUM_INPUTS lane beats.
// Define NV_MINMAX_SCATTER_ERR_EN to add the sticky out-of-range flag err_oob / err_clr.
module nv_minmax_scatter
    import nv_minmax_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NUM_INPUTS = 2,
    localparam int INDEX_WIDTH = idx_width(NUM_INPUTS)
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic                   in_pvld,
    output logic                   in_prdy,
    input  logic [WIDTH-1:0]       in_value,
    input  logic [INDEX_WIDTH-1:0] in_index,
    input  logic [WIDTH-1:0]       in_fill,
    output logic                   out_pvld,
    input  logic                   out_prdy,
    output logic [WIDTH-1:0]       out_data,
    output logic [INDEX_WIDTH-1:0] out_pos,
    output logic                   out_last
`ifdef NV_MINMAX_SCATTER_ERR_EN
    ,
    output logic                   err_oob,
    input  logic                   err_clr
`endif
);

    localparam logic [INDEX_WIDTH-1:0] LAST_POS = INDEX_WIDTH'(NUM_INPUTS - 1);

    state_t                 state, state_nxt;
    logic [INDEX_WIDTH-1:0] pos, pos_nxt, index_q;
    logic [WIDTH-1:0]       value_q, fill_q;
    logic                   emit, fire_out, take, wrap;

    assign emit     = state == EMIT;
    assign out_pvld = emit;
    assign out_last = emit & (pos == LAST_POS);
    assign out_pos  = pos;
    // An out-of-range index never matches pos, so every lane falls through to fill.
    assign out_data = emit ? (pos == index_q ? value_q : fill_q) : '0;
    assign fire_out = emit & out_prdy;
    assign wrap     = fire_out & out_last;
    assign in_prdy  = !emit | wrap;
    assign take     = in_pvld & in_prdy;

    always_comb begin
        state_nxt = take ? EMIT : wrap ? IDLE : state;
        pos_nxt   = (take | wrap) ? '0 : fire_out ? pos + 1'b1 : pos;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state <= IDLE;
            pos   <= '0;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            value_q <= '0;
            index_q <= '0;
            fill_q  <= '0;
        end else if (take) begin
            value_q <= in_value;
            index_q <= in_index;
            fill_q  <= in_fill;
        end
    end

`ifdef NV_MINMAX_SCATTER_ERR_EN
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn)
            err_oob <= 1'b0;
        else if (take && int'(in_index) >= NUM_INPUTS)
            err_oob <= 1'b1;
        else if (err_clr)
            err_oob <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_nv_minmax_scatter.sv
// tb_nv_minmax_scatter: directed scoreboard bench for a 4-lane and a 3-lane scatter instance.
module tb_nv_minmax_scatter;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic       a_ivld, a_irdy, a_ordy, a_ovld, a_last;
    logic [7:0] a_val, a_fill, a_data;
    logic [1:0] a_idx, a_pos;
    logic       b_ivld, b_irdy, b_ordy, b_ovld, b_last;
    logic [7:0] b_val, b_fill, b_data;
    logic [1:0] b_idx, b_pos;
`ifdef NV_MINMAX_SCATTER_ERR_EN
    logic       a_err, b_err;
    logic       a_clr = 1'b0;
    logic       b_clr = 1'b0;
`endif

    nv_minmax_scatter #(.WIDTH(8), .NUM_INPUTS(4)) dut4 (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .in_pvld(a_ivld), .in_prdy(a_irdy), .in_value(a_val), .in_index(a_idx), .in_fill(a_fill),
        .out_pvld(a_ovld), .out_prdy(a_ordy), .out_data(a_data), .out_pos(a_pos), .out_last(a_last)
`ifdef NV_MINMAX_SCATTER_ERR_EN
        , .err_oob(a_err), .err_clr(a_clr)
`endif
    );

    nv_minmax_scatter #(.WIDTH(8), .NUM_INPUTS(3)) dut3 (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .in_pvld(b_ivld), .in_prdy(b_irdy), .in_value(b_val), .in_index(b_idx), .in_fill(b_fill),
        .out_pvld(b_ovld), .out_prdy(b_ordy), .out_data(b_data), .out_pos(b_pos), .out_last(b_last)
`ifdef NV_MINMAX_SCATTER_ERR_EN
        , .err_oob(b_err), .err_clr(b_clr)
`endif
    );

    typedef struct {
        logic [7:0] d;
        logic [1:0] p;
        logic       l;
    } beat_t;

    beat_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard tick for dut4: pop on output handshake, push a window on input acceptance.
    task automatic tick();
        beat_t b;
        @(negedge clk);
        if (a_ovld && a_ordy) begin
            if (q.size() == 0) chk("unexpected_beat", 32'(a_ovld), 0);
            else begin
                b = q.pop_front();
                chk("beat_data", 32'(a_data), 32'(b.d));
                chk("beat_pos", 32'(a_pos), 32'(b.p));
                chk("beat_last", 32'(a_last), 32'(b.l));
            end
        end
        if (a_ivld && a_irdy)
            for (int p = 0; p < 4; p++) begin
                b.d = (p == int'(a_idx)) ? a_val : a_fill;
                b.p = 2'(p);
                b.l = (p == 3);
                q.push_back(b);
            end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] v, input logic [1:0] i, input logic [7:0] f);
        a_ivld = 1'b1;
        a_val  = v;
        a_idx  = i;
        a_fill = f;
    endtask

    initial begin
        rstn = 1'b0;
        {a_ivld, a_ordy, a_val, a_idx, a_fill} = '0;
        {b_ivld, b_ordy, b_val, b_idx, b_fill} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ovld", 32'(a_ovld), 0);
        chk("rst_data", 32'(a_data), 0);
        chk("rst_pos", 32'(a_pos), 0);
        chk("rst_last", 32'(a_last), 0);
        rstn = 1'b1;
        #1;
        chk("rst_irdy", 32'(a_irdy), 1);
`ifdef NV_MINMAX_SCATTER_ERR_EN
        chk("rst_err", 32'(b_err), 0);
`endif

        // single window, value on lane 2
        a_ordy = 1'b1;
        offer(8'h5A, 2'd2, 8'h00);
        tick();
        a_ivld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_ovld", 32'(a_ovld), 1);
            tick();
        end
        chk("t1_idle", 32'(a_ovld), 0);
        chk("t1_qempty", q.size(), 0);

        // back-to-back windows with zero bubble
        offer(8'h11, 2'd0, 8'hEE);
        tick();
        offer(8'h22, 2'd3, 8'h33);
        for (int i = 0; i < 4; i++) begin
            chk("t2_ovld_a", 32'(a_ovld), 1);
            chk("t2_irdy", 32'(a_irdy), 32'(i == 3));
            tick();
        end
        a_ivld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_ovld_b", 32'(a_ovld), 1);
            chk("t2_pos_b", 32'(a_pos), i);
            tick();
        end
        chk("t2_idle", 32'(a_ovld), 0);
        chk("t2_qempty", q.size(), 0);

        // backpressure holds pos 1
        offer(8'h77, 2'd1, 8'h10);
        tick();
        a_ivld = 1'b0;
        tick();
        a_ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_ovld", 32'(a_ovld), 1);
            chk("t3_data", 32'(a_data), 32'h77);
            chk("t3_pos", 32'(a_pos), 1);
            chk("t3_last", 32'(a_last), 0);
            chk("t3_irdy", 32'(a_irdy), 0);
            tick();
        end
        a_ordy = 1'b1;
        repeat (3) tick();
        chk("t3_idle", 32'(a_ovld), 0);
        chk("t3_qempty", q.size(), 0);

        // 3-lane instance, out-of-range index
        b_ordy = 1'b1;
        chk("t4_irdy", 32'(b_irdy), 1);
        {b_ivld, b_val, b_idx, b_fill} = {1'b1, 8'h99, 2'd3, 8'hFF};
        tick();
        b_ivld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_ovld", 32'(b_ovld), 1);
            chk("t4_data", 32'(b_data), 32'hFF);
            chk("t4_pos", 32'(b_pos), i);
            chk("t4_last", 32'(b_last), 32'(i == 2));
            tick();
        end
        chk("t4_idle", 32'(b_ovld), 0);
`ifdef NV_MINMAX_SCATTER_ERR_EN
        chk("t4_err_sticky", 32'(b_err), 1);
        chk("t4_err_other", 32'(a_err), 0);
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        chk("t4_err_clr", 32'(b_err), 0);
        {b_ivld, b_idx} = {1'b1, 2'd3};
        b_clr = 1'b1;
        tick();
        {b_ivld, b_clr} = 2'b00;
        chk("t4_set_wins", 32'(b_err), 1);
        repeat (3) tick();
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        chk("t4_err_clr2", 32'(b_err), 0);
`endif

        // reset mid-window
        offer(8'h42, 2'd2, 8'h01);
        tick();
        a_ivld = 1'b0;
        repeat (2) tick();
        chk("t5_pos2", 32'(a_pos), 2);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_ovld", 32'(a_ovld), 0);
        chk("t5_rst_data", 32'(a_data), 0);
        chk("t5_rst_pos", 32'(a_pos), 0);
        chk("t5_rst_last", 32'(a_last), 0);
        q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("t5_irdy", 32'(a_irdy), 1);
        offer(8'h05, 2'd1, 8'h09);
        tick();
        a_ivld = 1'b0;
        chk("t5_restart_pos", 32'(a_pos), 0);
        repeat (4) tick();
        chk("t5_idle", 32'(a_ovld), 0);
        chk("t5_qempty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
